// File: rtl/rvx_core_decode_queue.sv
`default_nettype none
// ==== rvx_core_decode_queue: RV32I/Zicsr (+optional M) decoder feeding a DEPTH-entry valid/ready queue ====
// ==== Rev 1.0 ====
module rvx_core_decode_queue #(
  parameter int unsigned DEPTH              = 2,
  parameter bit          ENABLE_M_EXTENSION = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instruction,
  input  logic [31:0]              in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instruction,
  output logic [3:0]               alu_operation_code_s2,
  output logic                     muldiv_s2,
  output logic [2:0]               muldiv_operation_s2,
  output logic                     alu_2nd_operand_sel_s2,
  output logic                     branch_s2,
  output logic                     jump_s2,
  output logic                     load_s2,
  output logic                     store_s2,
  output logic                     load_unsigned_s2,
  output logic                     ecall_s2,
  output logic                     ebreak_s2,
  output logic                     mret_s2,
  output logic                     csr_write_request_s2,
  output logic                     integer_file_write_request_s2,
  output logic                     target_address_sel_s2,
  output logic                     illegal_instruction_s2,
  output logic [1:0]               load_size_s2,
  output logic [2:0]               csr_operation_s2,
  output logic [2:0]               immediate_type_s2,
  output logic [2:0]               writeback_mux_sel_s2,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];
  localparam logic [AW:0]   ONE_COUNT  = 1;
  localparam logic [AW-1:0] ONE_PTR    = 1;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] IMM_R = 3'd0;
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [2:0] IMM_J = 3'd5;
  localparam logic [2:0] IMM_Z = 3'd6;

  localparam logic [2:0] WB_ALU    = 3'd1;
  localparam logic [2:0] WB_LOAD   = 3'd2;
  localparam logic [2:0] WB_UPPER  = 3'd3;
  localparam logic [2:0] WB_TARGET = 3'd4;
  localparam logic [2:0] WB_CSR    = 3'd5;
  localparam logic [2:0] WB_PC4    = 3'd6;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [3:0]  alu_op;
    logic        muldiv;
    logic [2:0]  muldiv_op;
    logic        alu_sel;
    logic        branch;
    logic        jump;
    logic        load;
    logic        store;
    logic        load_unsigned;
    logic        ecall;
    logic        ebreak;
    logic        mret;
    logic        csr_write;
    logic        int_write;
    logic        target_sel;
    logic        illegal;
    logic [1:0]  load_size;
    logic [2:0]  csr_op;
    logic [2:0]  imm_type;
    logic [2:0]  wb_sel;
  } bundle_t;

  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic          legal;
  logic          imm_arith;
  logic          is_muldiv;
  bundle_t       dec;

  always_comb begin
    opcode    = in_instruction[6:0];
    funct3    = in_instruction[14:12];
    funct7    = in_instruction[31:25];
    is_muldiv = (opcode == OPC_OP) && (funct7 == 7'b0000001);
    // Non-shift OP-IMM forms carry immediate bits in [30], not a sub/sra select.
    imm_arith = (opcode == OPC_OP_IMM) && (funct3[1:0] != 2'b01);
    legal     = 1'b0;
    dec             = '0;
    dec.pc          = in_pc;
    dec.instruction = in_instruction;
    dec.alu_op      = {in_instruction[30] & ~imm_arith, funct3};
    dec.load_size   = funct3[1:0];
    dec.csr_op      = funct3;
    dec.imm_type    = IMM_I;
    case (opcode)
      OPC_LOAD: begin
        legal             = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
        dec.load          = 1'b1;
        dec.load_unsigned = funct3[2];
        dec.int_write     = 1'b1;
        dec.wb_sel        = WB_LOAD;
      end
      OPC_STORE: begin
        legal        = ~funct3[2] && (funct3[1:0] != 2'b11);
        dec.store    = 1'b1;
        dec.imm_type = IMM_S;
      end
      OPC_BRANCH: begin
        legal        = funct3[2:1] != 2'b01;
        dec.branch   = 1'b1;
        dec.imm_type = IMM_B;
      end
      OPC_JALR: begin
        legal          = funct3 == 3'b000;
        dec.jump       = 1'b1;
        dec.target_sel = 1'b1;
        dec.int_write  = 1'b1;
        dec.wb_sel     = WB_PC4;
      end
      OPC_JAL: begin
        legal         = 1'b1;
        dec.jump      = 1'b1;
        dec.int_write = 1'b1;
        dec.wb_sel    = WB_PC4;
        dec.imm_type  = IMM_J;
      end
      OPC_LUI, OPC_AUIPC: begin
        legal         = 1'b1;
        dec.int_write = 1'b1;
        dec.wb_sel    = opcode[5] ? WB_UPPER : WB_TARGET;
        dec.imm_type  = IMM_U;
      end
      OPC_OP_IMM: begin
        legal         = imm_arith || (funct7 == 7'b0000000) ||
                        ((funct3 == 3'b101) && (funct7 == 7'b0100000));
        dec.int_write = 1'b1;
        dec.wb_sel    = WB_ALU;
      end
      OPC_OP: begin
        legal         = (funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))) ||
                        (is_muldiv && ENABLE_M_EXTENSION);
        dec.muldiv    = is_muldiv;
        dec.muldiv_op = is_muldiv ? funct3 : 3'b000;
        dec.int_write = 1'b1;
        dec.wb_sel    = WB_ALU;
        dec.imm_type  = IMM_R;
      end
      OPC_MISC_MEM: begin
        legal = funct3[2:1] == 2'b00;
      end
      OPC_SYSTEM: begin
        if (funct3 == 3'b000) begin
          dec.ecall  = in_instruction == 32'h0000_0073;
          dec.ebreak = in_instruction == 32'h0010_0073;
          dec.mret   = in_instruction == 32'h3020_0073;
          legal      = dec.ecall || dec.ebreak || dec.mret;
        end else begin
          legal         = funct3 != 3'b100;
          // CSRRS/CSRRC with rs1=x0 are pure reads.
          dec.csr_write = ~(funct3[1] && (in_instruction[19:15] == 5'd0));
          dec.int_write = 1'b1;
          dec.wb_sel    = WB_CSR;
          dec.imm_type  = funct3[2] ? IMM_Z : IMM_I;
        end
      end
      default: legal = 1'b0;
    endcase
    dec.alu_sel = opcode[5];
    if (!legal) begin
      dec.muldiv        = 1'b0;
      dec.muldiv_op     = 3'b000;
      dec.alu_sel       = 1'b0;
      dec.branch        = 1'b0;
      dec.jump          = 1'b0;
      dec.load          = 1'b0;
      dec.store         = 1'b0;
      dec.load_unsigned = 1'b0;
      dec.ecall         = 1'b0;
      dec.ebreak        = 1'b0;
      dec.mret          = 1'b0;
      dec.csr_write     = 1'b0;
      dec.int_write     = 1'b0;
      dec.target_sel    = 1'b0;
      dec.wb_sel        = 3'b000;
      dec.illegal       = 1'b1;
    end
  end

  bundle_t       mem_q [DEPTH];
  bundle_t       mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] wr_ptr_d;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_ptr_d;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          push;
  logic          pop;
  bundle_t       head;

  always_comb begin
    in_ready  = ~reset & (count_q != FULL_COUNT);
    out_valid = count_q != '0;
    // A flush drops the entry even if the handshake completes this cycle.
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (push && (wr_ptr_q == AW'(i))) mem_d[i] = dec;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ONE_PTR;
      if (pop)  rd_ptr_d = rd_ptr_q + ONE_PTR;
      case ({push, pop})
        2'b10:   count_d = count_q + ONE_COUNT;
        2'b01:   count_d = count_q - ONE_COUNT;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  always_comb begin
    head = mem_q[rd_ptr_q];
    if (!out_valid) head = '0;
    out_pc                        = head.pc;
    out_instruction               = head.instruction;
    alu_operation_code_s2         = head.alu_op;
    muldiv_s2                     = head.muldiv;
    muldiv_operation_s2           = head.muldiv_op;
    alu_2nd_operand_sel_s2        = head.alu_sel;
    branch_s2                     = head.branch;
    jump_s2                       = head.jump;
    load_s2                       = head.load;
    store_s2                      = head.store;
    load_unsigned_s2              = head.load_unsigned;
    ecall_s2                      = head.ecall;
    ebreak_s2                     = head.ebreak;
    mret_s2                       = head.mret;
    csr_write_request_s2          = head.csr_write;
    integer_file_write_request_s2 = head.int_write;
    target_address_sel_s2         = head.target_sel;
    illegal_instruction_s2        = head.illegal;
    load_size_s2                  = head.load_size;
    csr_operation_s2              = head.csr_op;
    immediate_type_s2             = head.imm_type;
    writeback_mux_sel_s2          = head.wb_sel;
    occupancy                     = count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_rvx_core_decode_queue.sv
`default_nettype none
// Two decode queues (M off / M on) share one stimulus stream and are compared every
// cycle against a queue-of-instructions model that decodes from the ISA rules.
module tb_rvx_core_decode_queue;
  localparam int DEPTH = 2;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_instruction = '0;
  logic [31:0] in_pc = '0;
  always #5 clock = ~clock;

  logic [1:0] in_ready, out_valid, muldiv, alu_sel, branch, jump, load, store, lunsigned;
  logic [1:0] ecall, ebreak, mret, csrw, intw, tsel, illegal;
  logic [1:0][31:0] out_pc, out_instr;
  logic [1:0][3:0]  alu_op;
  logic [1:0][2:0]  md_op, csr_op, imm_type, wb_sel;
  logic [1:0][1:0]  load_size;
  logic [1:0][OW-1:0] occupancy;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rvx_core_decode_queue #(.DEPTH(DEPTH), .ENABLE_M_EXTENSION(g == 1)) dut (
      .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[g]),
      .in_instruction(in_instruction), .in_pc(in_pc), .out_valid(out_valid[g]), .out_ready(out_ready),
      .out_pc(out_pc[g]), .out_instruction(out_instr[g]), .alu_operation_code_s2(alu_op[g]),
      .muldiv_s2(muldiv[g]), .muldiv_operation_s2(md_op[g]), .alu_2nd_operand_sel_s2(alu_sel[g]),
      .branch_s2(branch[g]), .jump_s2(jump[g]), .load_s2(load[g]), .store_s2(store[g]),
      .load_unsigned_s2(lunsigned[g]), .ecall_s2(ecall[g]), .ebreak_s2(ebreak[g]), .mret_s2(mret[g]),
      .csr_write_request_s2(csrw[g]), .integer_file_write_request_s2(intw[g]),
      .target_address_sel_s2(tsel[g]), .illegal_instruction_s2(illegal[g]),
      .load_size_s2(load_size[g]), .csr_operation_s2(csr_op[g]), .immediate_type_s2(imm_type[g]),
      .writeback_mux_sel_s2(wb_sel[g]), .occupancy(occupancy[g]));
  end

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [95:0] act_bundle(int g);
    return {out_pc[g], out_instr[g], alu_op[g], muldiv[g], md_op[g], alu_sel[g], branch[g], jump[g],
            load[g], store[g], lunsigned[g], ecall[g], ebreak[g], mret[g], csrw[g], intw[g], tsel[g],
            illegal[g], load_size[g], csr_op[g], imm_type[g], wb_sel[g]};
  endfunction

  // Expected decode by instruction class; immediate codes R0 I1 S2 B3 U4 J5 Z6,
  // writeback codes none0 ALU1 LOAD2 LUI3 AUIPC4 CSR5 PC+4 6.
  function automatic logic [95:0] exp_bundle(logic [31:0] pc, logic [31:0] ins, bit m);
    logic [6:0] op, f7;
    logic [2:0] f3, imm, wb, mdop;
    bit ok, mdv, br, jp, ld, st, lu, ec, eb, mr, cw, iw, ts, a3;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    {ok, mdv, br, jp, ld, st, lu, ec, eb, mr, cw, iw, ts} = '0;
    imm = 3'd1; wb = 3'd0; mdop = 3'd0;
    a3 = (op == 7'h13 && f3 != 3'd1 && f3 != 3'd5) ? 1'b0 : ins[30];
    case (op)
      7'h03: begin ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; ld = 1; lu = f3[2]; iw = 1; wb = 3'd2; end
      7'h23: begin ok = f3 < 3'd3; st = 1; imm = 3'd2; end
      7'h63: begin ok = f3 != 3'd2 && f3 != 3'd3; br = 1; imm = 3'd3; end
      7'h67: begin ok = f3 == 3'd0; jp = 1; ts = 1; iw = 1; wb = 3'd6; end
      7'h6F: begin ok = 1; jp = 1; iw = 1; wb = 3'd6; imm = 3'd5; end
      7'h37: begin ok = 1; iw = 1; wb = 3'd3; imm = 3'd4; end
      7'h17: begin ok = 1; iw = 1; wb = 3'd4; imm = 3'd4; end
      7'h13: begin
        ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        iw = 1; wb = 3'd1;
      end
      7'h33: begin
        mdv = f7 == 7'h01;
        ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (mdv && m);
        if (mdv) mdop = f3;
        iw = 1; wb = 3'd1; imm = 3'd0;
      end
      7'h0F: ok = f3 < 3'd2;
      7'h73: begin
        if (f3 == 3'd0) begin
          ec = ins == 32'h73; eb = ins == 32'h0010_0073; mr = ins == 32'h3020_0073;
          ok = ec || eb || mr;
        end else begin
          ok = f3 != 3'd4; cw = !(f3[1] && ins[19:15] == 5'd0); iw = 1; wb = 3'd5;
          imm = f3[2] ? 3'd6 : 3'd1;
        end
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      {mdv, br, jp, ld, st, lu, ec, eb, mr, cw, iw, ts} = '0;
      wb = 3'd0; mdop = 3'd0;
    end
    return {pc, ins, a3, f3, mdv, mdop, ok ? op[5] : 1'b0, br, jp, ld, st, lu, ec, eb, mr, cw, iw, ts,
            !ok, f3[1:0], f3, imm, wb};
  endfunction

  logic [31:0] mq_ins[$];
  logic [31:0] mq_pc[$];
  bit can_push;
  always @(posedge clock) begin
    if (reset || flush) begin
      mq_ins.delete();
      mq_pc.delete();
    end else begin
      can_push = in_valid && (mq_ins.size() < DEPTH);
      if (out_ready && mq_ins.size() > 0) begin
        void'(mq_ins.pop_front());
        void'(mq_pc.pop_front());
      end
      if (can_push) begin
        mq_ins.push_back(in_instruction);
        mq_pc.push_back(in_pc);
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clock) begin
    if (chk_en) begin
      for (int g = 0; g < 2; g++) begin
        check($sformatf("in_ready[%0d]", g), in_ready[g], !reset && (mq_ins.size() != DEPTH));
        check($sformatf("out_valid[%0d]", g), out_valid[g], mq_ins.size() != 0);
        check($sformatf("occupancy[%0d]", g), occupancy[g], mq_ins.size());
        check($sformatf("payload[%0d]", g), act_bundle(g),
              (mq_ins.size() != 0) ? exp_bundle(mq_pc[0], mq_ins[0], g == 1) : 96'd0);
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  task automatic drive(logic v, logic [31:0] ins, logic [31:0] pc);
    in_valid = v; in_instruction = ins; in_pc = pc;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] ops [11];
    logic [6:0] f7s [3];
    ops = '{7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h13, 7'h33, 7'h0F, 7'h73};
    f7s = '{7'h00, 7'h20, 7'h01};
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r = r;
      1: case ($urandom_range(0, 2))
           0: r = 32'h0000_0073;
           1: r = 32'h0010_0073;
           default: r = 32'h3020_0073;
         endcase
      2, 3: begin
        r[6:0] = ($urandom_range(0, 1) != 0) ? 7'h33 : 7'h13;
        r[31:25] = f7s[$urandom_range(0, 2)];
      end
      default: r[6:0] = ops[$urandom_range(0, 10)];
    endcase
    return r;
  endfunction

  logic [31:0] stream [8];
  logic [7:0]  stream_flags [8];

  initial begin
    stream = '{32'h0000_0073, 32'h0010_0073, 32'h3020_0073, 32'h3001_10F3,
               32'h0020_A223, 32'h0080_A183, 32'h0020_8463, 32'h0100_00EF};
    stream_flags = '{8'b1000_0000, 8'b0100_0000, 8'b0010_0000, 8'b0001_0000,
                     8'b0000_1000, 8'b0000_0100, 8'b0000_0010, 8'b0000_0001};
    reset = 1'b1;
    repeat (3) tick();
    chk_en = 1;
    check("reset_in_ready", in_ready[0], 1'b0);
    check("reset_out_valid", out_valid[0], 1'b0);
    check("reset_occupancy", occupancy[0], 0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", in_ready[0], 1'b1);

    // addi x1,x0,5 held at the head
    drive(1, 32'h0050_0093, 32'h100);
    tick();
    in_valid = 0;
    check("addi_out_valid", out_valid[0], 1'b1);
    check("addi_imm_type", imm_type[0], 3'd1);
    check("addi_wb_sel", wb_sel[0], 3'd1);
    check("addi_int_write", intw[0], 1'b1);
    check("addi_occupancy", occupancy[0], 1);
    tick();
    check("addi_occupancy_held", occupancy[0], 1);
    check("addi_pc_held", out_pc[0], 32'h100);
    out_ready = 1; tick(); out_ready = 0;

    // fill a DEPTH=2 queue and try a third push
    drive(1, 32'h0010_0113, 32'h200); tick();
    drive(1, 32'h0020_81B3, 32'h204); tick();
    drive(1, 32'h4020_81B3, 32'h208);
    check("full_in_ready", in_ready[0], 1'b0);
    check("full_occupancy", occupancy[0], 2);
    tick();
    in_valid = 0; out_ready = 1;
    check("drain0_pc", out_pc[0], 32'h200);
    check("drain0_instr", out_instr[0], 32'h0010_0113);
    tick();
    check("drain1_pc", out_pc[0], 32'h204);
    check("drain1_instr", out_instr[0], 32'h0020_81B3);
    tick();
    check("drained_out_valid", out_valid[0], 1'b0);
    out_ready = 0;

    // mul x3,x1,x2 with and without the M extension
    drive(1, 32'h0220_81B3, 32'h300); tick(); in_valid = 0;
    check("mul_m0_illegal", illegal[0], 1'b1);
    check("mul_m0_muldiv", muldiv[0], 1'b0);
    check("mul_m0_int_write", intw[0], 1'b0);
    check("mul_m1_illegal", illegal[1], 1'b0);
    check("mul_m1_muldiv", muldiv[1], 1'b1);
    check("mul_m1_op", md_op[1], 3'b000);
    check("mul_m1_int_write", intw[1], 1'b1);
    out_ready = 1; tick(); out_ready = 0;

    // flush with a full queue and with a completing handshake
    drive(1, 32'h0010_0113, 32'h400); tick();
    drive(1, 32'h0020_0113, 32'h404); tick();
    drive(1, 32'h0070_0393, 32'h408); flush = 1; tick(); flush = 0; in_valid = 0;
    check("flush_full_occupancy", occupancy[0], 0);
    check("flush_full_out_valid", out_valid[0], 1'b0);
    drive(1, 32'h0010_0113, 32'h410); tick();
    drive(1, 32'h0070_0393, 32'h414); flush = 1;
    check("flush_push_ready", in_ready[0], 1'b1);
    tick(); flush = 0; in_valid = 0;
    check("flush_push_occupancy", occupancy[0], 0);
    tick();
    check("flush_push_dropped", out_valid[0], 1'b0);

    // back-to-back stream with a consumer that never stalls
    out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      drive(1, stream[k], 32'h500 + 32'(4 * k));
      tick();
      check($sformatf("stream%0d_out_valid", k), out_valid[0], 1'b1);
      check($sformatf("stream%0d_instr", k), out_instr[0], stream[k]);
      check($sformatf("stream%0d_flags", k),
            {ecall[0], ebreak[0], mret[0], csrw[0], store[0], load[0], branch[0], jump[0]},
            stream_flags[k]);
    end
    in_valid = 0; tick();
    check("stream_end_out_valid", out_valid[0], 1'b0);
    out_ready = 0;

    // reset with one entry queued
    drive(1, 32'h0050_0093, 32'h600); tick(); in_valid = 0;
    reset = 1; #1;
    check("midreset_in_ready", in_ready[0], 1'b0);
    tick();
    check("midreset_occupancy", occupancy[0], 0);
    check("midreset_out_valid", out_valid[0], 1'b0);
    check("midreset_payload0", act_bundle(0), 96'd0);
    check("midreset_payload1", act_bundle(1), 96'd0);
    reset = 0;

    for (int n = 0; n < 3000; n++) begin
      in_valid       = $urandom_range(0, 3) != 0;
      out_ready      = $urandom_range(0, 3) != 0;
      flush          = $urandom_range(0, 49) == 0;
      reset          = $urandom_range(0, 199) == 0;
      in_instruction = rand_instr();
      in_pc          = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      tick();
    end
    reset = 0; flush = 0; in_valid = 0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
